ahb_out_port: RTL and testbench

AHB-Lite slave that buffers 16-bit values written by the M0 and presents them one at a time on an external output port with a valid/acknowledge handshake. It is the output-direction counterpart of the switch-input peripheral. An external consumer (display logic or an operator push-button, debounced upstream) acknowledges each value. A DEPTH-entry FIFO decouples bus writes from consumption; writes to a full FIFO either stall the bus or are dropped with a sticky overflow flag.

---
 rtl/ahb_out_port.sv | 124 ++++++++++++
 tb/tb_ahb_out_port.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_out_port.sv
// rtl/ahb_out_port.sv - AHB-Lite slave feeding a FIFO of 16-bit values to an acknowledged output port
`timescale 1ns/1ps

module ahb_out_port #(
    parameter int DEPTH         = 4,
    parameter bit STALL_ON_FULL = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [15:0] OutData,
    output logic        OutValid,
    input  logic        OutAck
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic            write_en;
    logic            read_en;
    logic [1:0]      addr_q;

    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            overflow;
    logic            last_ack;

    logic            full;
    logic            empty;
    logic            data_hit;
    logic            stall;
    logic            push;
    logic            pop;
    logic            drop;
    logic            clr_ovf;
    logic [31:0]     status;

    logic            unused_bits;
    assign unused_bits = &{1'b0, HSIZE, HADDR[31:3], HADDR[0], HWDATA[31:16]};

    // Captured values are held while HREADY is low so a stalled write stays pending.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            write_en <= 1'b0;
            read_en  <= 1'b0;
            addr_q   <= 2'd0;
        end else if (HREADY) begin
            write_en <= HSEL & (HTRANS != 2'b00) & HWRITE;
            read_en  <= HSEL & (HTRANS != 2'b00) & ~HWRITE;
            addr_q   <= HADDR[2:1];
        end
    end

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign data_hit = write_en & (addr_q == 2'd0);
    assign stall    = data_hit & full & STALL_ON_FULL;
    assign push     = data_hit & ~stall & ~full;
    assign drop     = data_hit & full & ~STALL_ON_FULL;
    assign clr_ovf  = write_en & (addr_q == 2'd2) & HWDATA[2];
    assign pop      = OutAck & ~last_ack & ~empty;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            last_ack <= 1'b0;
        end else begin
            last_ack <= OutAck;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= HWDATA[15:0];
        end
    end

    assign OutValid  = ~empty;
    assign OutData   = empty ? 16'd0 : mem[rd_ptr];
    assign HREADYOUT = ~stall;
    assign status    = {20'd0, 8'(count), 1'b0, overflow, full, ~empty};

    always_comb begin
        HRDATA = 32'd0;
        if (read_en) begin
            case (addr_q)
                2'd0:    HRDATA = {16'd0, OutData};
                2'd2:    HRDATA = status;
                default: HRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_out_port.sv
// tb/tb_ahb_out_port.sv - scoreboard bench for ahb_out_port, stalling and dropping variants
`timescale 1ns/1ps

module tb_ahb_out_port;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    always #5 HCLK = ~HCLK;

    logic [31:0] haddr [2];
    logic [31:0] hwdata [2];
    logic [2:0]  hsize [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic        hsel [2];
    logic        out_ack [2];
    logic [31:0] hrdata [2];
    logic        hreadyout [2];
    logic [15:0] out_data [2];
    logic        out_valid [2];

    ahb_out_port #(.DEPTH(4), .STALL_ON_FULL(1'b1)) u_stall (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr[0]), .HWDATA(hwdata[0]),
        .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HREADY(hreadyout[0]),
        .HSEL(hsel[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]),
        .OutData(out_data[0]), .OutValid(out_valid[0]), .OutAck(out_ack[0])
    );

    ahb_out_port #(.DEPTH(4), .STALL_ON_FULL(1'b0)) u_drop (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(haddr[1]), .HWDATA(hwdata[1]),
        .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HREADY(hreadyout[1]),
        .HSEL(hsel[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]),
        .OutData(out_data[1]), .OutValid(out_valid[1]), .OutAck(out_ack[1])
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_out [2][$];
    logic [31:0] exp_rd [2][$];
    logic        rd_active [2];
    logic        ack_seen [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a rising acknowledge seen by the DUT with data present is a pop of the queue head.
    always @(negedge HCLK) begin
        for (int p = 0; p < 2; p++) begin
            if (HRESETn && out_ack[p] && !ack_seen[p] && out_valid[p]) begin
                if (exp_out[p].size() == 0) begin
                    check($sformatf("unexpected_pop%0d", p), 32'(out_valid[p]), 32'd0);
                end else begin
                    check($sformatf("pop_data%0d", p), {16'd0, out_data[p]},
                          {16'd0, exp_out[p].pop_front()});
                end
            end
            ack_seen[p] = HRESETn ? out_ack[p] : 1'b0;
            if (rd_active[p] && hreadyout[p]) begin
                if (exp_rd[p].size() == 0) begin
                    check($sformatf("unexpected_read%0d", p), hrdata[p], 32'hffff_ffff);
                end else begin
                    check($sformatf("hrdata%0d", p), hrdata[p], exp_rd[p].pop_front());
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic addr_phase(input int p, input logic [31:0] a, input logic wr);
        haddr[p]  = a;
        hsel[p]   = 1'b1;
        htrans[p] = 2'b10;
        hwrite[p] = wr;
        step();
        hsel[p]   = 1'b0;
        htrans[p] = 2'b00;
        hwrite[p] = 1'b0;
    endtask

    task automatic ahb_write(input int p, input logic [31:0] a, input logic [31:0] d, output int waits);
        addr_phase(p, a, 1'b1);
        hwdata[p] = d;
        waits = 0;
        while (!hreadyout[p] && waits < 50) begin
            step();
            waits++;
        end
        if (!hreadyout[p]) check("write_timeout", 32'(hreadyout[p]), 32'd1);
        step();
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d);
        int waits;
        ahb_write(p, a, d, waits);
    endtask

    task automatic push_wr(input int p, input logic [15:0] d);
        exp_out[p].push_back(d);
        wr(p, 32'h0, {16'd0, d});
    endtask

    task automatic rd(input int p, input logic [31:0] a, input logic [31:0] exp);
        int waits = 0;
        addr_phase(p, a, 1'b0);
        exp_rd[p].push_back(exp);
        rd_active[p] = 1'b1;
        while (!hreadyout[p] && waits < 50) begin
            step();
            waits++;
        end
        if (!hreadyout[p]) check("read_timeout", 32'(hreadyout[p]), 32'd1);
        step();
        rd_active[p] = 1'b0;
    endtask

    task automatic ack_pulse(input int p);
        out_ack[p] = 1'b1;
        step();
        out_ack[p] = 1'b0;
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        logic [15:0] fill [4];
        fill[0] = 16'h1111; fill[1] = 16'h2222; fill[2] = 16'h3333; fill[3] = 16'h4444;
        HRESETn = 1'b0;
        for (int p = 0; p < 2; p++) begin
            haddr[p] = '0; hwdata[p] = '0; hsize[p] = 3'b001; htrans[p] = '0;
            hwrite[p] = 1'b0; hsel[p] = 1'b0; out_ack[p] = 1'b0;
            rd_active[p] = 1'b0; ack_seen[p] = 1'b0;
        end
        step(3);
        HRESETn = 1'b1;
        step();

        // Reset state
        for (int p = 0; p < 2; p++) begin
            check("reset_hreadyout", 32'(hreadyout[p]), 32'd1);
            check("reset_outvalid", 32'(out_valid[p]), 32'd0);
            check("reset_outdata", {16'd0, out_data[p]}, 32'd0);
            rd(p, 32'h4, 32'h0000_0000);
        end

        // Two writes, status and non-destructive head read
        push_wr(0, 16'h1234);
        push_wr(0, 16'hABCD);
        check("outvalid_after_write", 32'(out_valid[0]), 32'd1);
        check("outdata_head", {16'd0, out_data[0]}, 32'h0000_1234);
        rd(0, 32'h4, 32'h0000_0021);
        rd(0, 32'h0, 32'h0000_1234);
        rd(0, 32'h4, 32'h0000_0021);
        rd(0, 32'h2, 32'h0000_0000);
        wr(0, 32'h2, 32'h0000_5A5A);
        rd(0, 32'h4, 32'h0000_0021);

        // Held acknowledge pops exactly once
        out_ack[0] = 1'b1;
        step();
        check("outdata_after_pop", {16'd0, out_data[0]}, 32'h0000_ABCD);
        step(4);
        check("no_second_pop", {16'd0, out_data[0]}, 32'h0000_ABCD);
        rd(0, 32'h4, 32'h0000_0011);
        out_ack[0] = 1'b0;
        step();
        out_ack[0] = 1'b1;
        step();
        check("empty_outvalid", 32'(out_valid[0]), 32'd0);
        check("empty_outdata", {16'd0, out_data[0]}, 32'd0);
        out_ack[0] = 1'b0;
        step();

        // Stall on full, released by a pop
        for (int i = 0; i < 4; i++) push_wr(0, fill[i]);
        rd(0, 32'h4, 32'h0000_0043);
        addr_phase(0, 32'h0, 1'b1);
        hwdata[0] = 32'h0000_5555;
        check("stall_hreadyout", 32'(hreadyout[0]), 32'd0);
        step(3);
        check("stall_held", 32'(hreadyout[0]), 32'd0);
        out_ack[0] = 1'b1;
        step();
        check("stall_release", 32'(hreadyout[0]), 32'd1);
        exp_out[0].push_back(16'h5555);
        out_ack[0] = 1'b0;
        step();
        rd(0, 32'h4, 32'h0000_0043);
        for (int i = 0; i < 4; i++) ack_pulse(0);
        check("drained_outvalid", 32'(out_valid[0]), 32'd0);

        // Drop on full with sticky overflow
        for (int i = 0; i < 4; i++) push_wr(1, 16'h7001 + 16'(i));
        ahb_write(1, 32'h0, 32'h0000_9999, waits);
        check("drop_no_wait", 32'(waits), 32'd0);
        rd(1, 32'h4, 32'h0000_0047);
        check("drop_head_kept", {16'd0, out_data[1]}, 32'h0000_7001);
        wr(1, 32'h4, 32'h0000_0004);
        rd(1, 32'h4, 32'h0000_0043);

        // Rising ack while empty is lost; simultaneous push and pop
        ack_pulse(0);
        push_wr(0, 16'hA001);
        push_wr(0, 16'hA002);
        check("lost_ack_head", {16'd0, out_data[0]}, 32'h0000_A001);
        addr_phase(0, 32'h0, 1'b1);
        hwdata[0] = 32'h0000_A003;
        exp_out[0].push_back(16'hA003);
        out_ack[0] = 1'b1;
        step();
        out_ack[0] = 1'b0;
        check("push_pop_head", {16'd0, out_data[0]}, 32'h0000_A002);
        rd(0, 32'h4, 32'h0000_0021);
        ack_pulse(0);
        ack_pulse(0);

        // Reset asserted during a stall
        for (int i = 0; i < 4; i++) push_wr(0, 16'hB001 + 16'(i));
        addr_phase(0, 32'h0, 1'b1);
        hwdata[0] = 32'h0000_B005;
        check("pre_reset_stall", 32'(hreadyout[0]), 32'd0);
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_reset_hreadyout", 32'(hreadyout[0]), 32'd1);
        check("async_reset_outvalid", 32'(out_valid[0]), 32'd0);
        exp_out[0].delete();
        exp_out[1].delete();
        step(2);
        HRESETn = 1'b1;
        step(2);
        check("post_reset_outvalid", 32'(out_valid[0]), 32'd0);
        rd(0, 32'h4, 32'h0000_0000);
        rd(1, 32'h4, 32'h0000_0000);
        push_wr(0, 16'hC001);
        check("post_reset_push", {16'd0, out_data[0]}, 32'h0000_C001);
        ack_pulse(0);

        step(2);
        for (int p = 0; p < 2; p++) begin
            check("exp_out_left", 32'(exp_out[p].size()), 32'd0);
            check("exp_rd_left", 32'(exp_rd[p].size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
